reaction_timer_mp: RTL and testbench

REACTION_TIMER_MP -- requirements
Module: reaction_timer_mp

---
 rtl/reaction_timer_mp_if.sv | 35 +++
 rtl/reaction_timer_mp.sv | 172 +++++++++++++++++
 tb/tb_reaction_timer_mp.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_mp_if.sv
// Port bundle for reaction_timer_mp: round control and player inputs in, round status, results and display scan out.
// master drives start/user_trigger/random_delay; slave is the timer itself.
interface reaction_timer_mp_if #(
  parameter int N_PLAYERS = 2,
  parameter int N_DIGITS  = 4
);
  localparam int DSW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                            start;
  logic [N_PLAYERS-1:0]            user_trigger;
  logic [15:0]                     random_delay;
  logic                            react;
  logic [2:0]                      state_o;
  logic [N_PLAYERS*N_DIGITS*4-1:0] times;
  logic [N_PLAYERS-1:0]            done;
  logic [N_PLAYERS-1:0]            false_start;
  logic                            timeout;
  logic [2:0]                      winner;
  logic [N_DIGITS*4-1:0]           best_time;
  logic [DSW-1:0]                  digit_sel;
  logic [2:0]                      player_sel;
  logic [3:0]                      digit_out;

  modport master (
    output start, user_trigger, random_delay,
    input  react, state_o, times, done, false_start, timeout, winner, best_time,
           digit_sel, player_sel, digit_out
  );

  modport slave (
    input  start, user_trigger, random_delay,
    output react, state_o, times, done, false_start, timeout, winner, best_time,
           digit_sel, player_sel, digit_out
  );
endinterface

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: random arm delay, per-player BCD ms latch, winner/best tracking, display scan.
// All results register on the edge after the causing input; inputs are levels, so there is no backpressure.
module reaction_timer_mp #(
  parameter int N_PLAYERS   = 2,
  parameter int N_DIGITS    = 4,
  parameter int CLK_PER_MS  = 50000,
  parameter int DELAY_SCALE = 4
) (
  input logic                clk,
  input logic                rst,
  reaction_timer_mp_if.slave bus
);
  localparam int              TW      = N_DIGITS * 4;
  localparam int              DSW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int              PW      = $clog2(CLK_PER_MS);
  localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_PER_MS - 1);
  localparam logic [TW-1:0]   ALL9    = {N_DIGITS{4'h9}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_REACT = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_FOUL  = 3'd4;

  logic [2:0]              state;
  logic [31:0]             dly;
  logic [PW-1:0]           pre;
  logic [TW-1:0]           ms, ms_inc;
  logic                    ms_full, carry;
  logic [N_PLAYERS*TW-1:0] times_r, nxt_times;
  logic [N_PLAYERS-1:0]    done_r, nxt_done, hit, false_start_r;
  logic                    timeout_r;
  logic [2:0]              winner_r, nxt_win;
  logic [TW-1:0]           best_r, win_time;
  logic                    win_any;
  logic [DSW-1:0]          digit_sel_r;
  logic [2:0]              player_sel_r;
  logic [3:0]              digit_out_r, scan_digit;

  assign ms_full = (ms == ALL9);
  assign hit     = (state == S_REACT) ? (bus.user_trigger & ~done_r) : '0;

  always_comb begin
    ms_inc = ms;
    carry  = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (carry) begin
        if (ms[d*4 +: 4] == 4'd9) begin
          ms_inc[d*4 +: 4] = 4'd0;
        end else begin
          ms_inc[d*4 +: 4] = ms[d*4 +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  // Times and winner as they will stand after this edge, so SHOW entry sees this cycle's latches.
  always_comb begin
    nxt_done  = done_r | hit;
    nxt_times = times_r;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (hit[p])
        nxt_times[p*TW +: TW] = ms;
      else if (ms_full && !nxt_done[p])
        nxt_times[p*TW +: TW] = ALL9;
    end
    nxt_win  = 3'd0;
    win_time = ALL9;
    win_any  = 1'b0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (nxt_done[p] && (!win_any || nxt_times[p*TW +: TW] < win_time)) begin
        nxt_win  = 3'(p);
        win_time = nxt_times[p*TW +: TW];
        win_any  = 1'b1;
      end
    end
  end

  always_comb begin
    scan_digit = 4'd0;
    for (int p = 0; p < N_PLAYERS; p++)
      for (int d = 0; d < N_DIGITS; d++)
        if (player_sel_r == 3'(p) && digit_sel_r == DSW'(d))
          scan_digit = times_r[(p*N_DIGITS + d)*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      dly           <= '0;
      pre           <= '0;
      ms            <= '0;
      times_r       <= '0;
      done_r        <= '0;
      false_start_r <= '0;
      timeout_r     <= 1'b0;
      winner_r      <= 3'd0;
      best_r        <= ALL9;
      digit_sel_r   <= '0;
      player_sel_r  <= 3'd0;
      digit_out_r   <= 4'd0;
    end else begin
      case (state)
        S_WAIT: begin
          if (|bus.user_trigger) begin
            state         <= S_FOUL;
            false_start_r <= bus.user_trigger;
          end else if (dly == 32'd0) begin
            state <= S_REACT;
            pre   <= '0;
            ms    <= '0;
          end else begin
            dly <= dly - 32'd1;
          end
        end
        S_REACT: begin
          times_r <= nxt_times;
          done_r  <= nxt_done;
          if (pre == PRE_MAX) begin
            pre <= '0;
            if (!ms_full) ms <= ms_inc;
          end else begin
            pre <= pre + 1'b1;
          end
          if ((&nxt_done) || ms_full) begin
            state        <= S_SHOW;
            timeout_r    <= ~&nxt_done;
            winner_r     <= nxt_win;
            if (win_any && win_time < best_r) best_r <= win_time;
            digit_sel_r  <= '0;
            player_sel_r <= 3'd0;
            digit_out_r  <= 4'd0;
          end
        end
        default: begin
          if (bus.start) begin
            state         <= S_WAIT;
            dly           <= 32'(bus.random_delay) * 32'(DELAY_SCALE);
            times_r       <= '0;
            done_r        <= '0;
            false_start_r <= '0;
            timeout_r     <= 1'b0;
            digit_sel_r   <= '0;
            player_sel_r  <= 3'd0;
            digit_out_r   <= 4'd0;
          end else if (state == S_SHOW) begin
            digit_out_r <= scan_digit;
            if (digit_sel_r == DSW'(N_DIGITS - 1)) begin
              digit_sel_r  <= '0;
              player_sel_r <= (player_sel_r == 3'(N_PLAYERS - 1)) ? 3'd0 : player_sel_r + 3'd1;
            end else begin
              digit_sel_r <= digit_sel_r + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.react       = (state == S_REACT);
  assign bus.state_o     = state;
  assign bus.times       = times_r;
  assign bus.done        = done_r;
  assign bus.false_start = false_start_r;
  assign bus.timeout     = timeout_r;
  assign bus.winner      = winner_r;
  assign bus.best_time   = best_r;
  assign bus.digit_sel   = digit_sel_r;
  assign bus.player_sel  = player_sel_r;
  assign bus.digit_out   = digit_out_r;
endmodule

// File: tb/tb_reaction_timer_mp.sv
// Random and directed rounds against an integer-millisecond reference model of the reaction timer.
module tb_reaction_timer_mp;
  localparam int NP = 2, ND = 3, CPM = 4, DS = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reaction_timer_mp_if #(.N_PLAYERS(NP), .N_DIGITS(ND)) bus ();

  reaction_timer_mp #(
    .N_PLAYERS(NP), .N_DIGITS(ND), .CLK_PER_MS(CPM), .DELAY_SCALE(DS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: states 0 IDLE,1 WAIT,2 REACT,3 SHOW,4 FOUL; times held as plain ms integers.
  int          m_state, m_wait, m_w, m_k, m_best, m_win, m_scan, m_dout;
  int          m_t [NP];
  logic [NP-1:0] m_done, m_fs;
  logic        m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r = '0;
    for (int d = 0; d < ND; d++) r[d*4 +: 4] = 4'((v / (10 ** d)) % 10);
    return r;
  endfunction

  task automatic m_step();
    if (rst) begin
      m_state = 0; m_done = '0; m_fs = '0; m_to = 1'b0; m_t = '{default: 0};
      m_win = 0; m_best = 999; m_scan = 0; m_dout = 0; m_k = 0; m_w = 0; m_wait = 0;
      return;
    end
    case (m_state)
      1: begin
        if (bus.user_trigger != '0) begin
          m_state = 4; m_fs = bus.user_trigger;
        end else if (m_w == m_wait) begin
          m_state = 2; m_k = 0;
        end else m_w++;
      end
      2: begin
        int ms, wt;
        bit any;
        ms = m_k / CPM;
        for (int p = 0; p < NP; p++)
          if (bus.user_trigger[p] && !m_done[p]) begin m_t[p] = ms; m_done[p] = 1'b1; end
        if (m_done == '1 || ms == 999) begin
          m_to = (m_done != '1);
          for (int p = 0; p < NP; p++) if (!m_done[p]) m_t[p] = 999;
          any = 0; wt = 0; m_win = 0;
          for (int p = 0; p < NP; p++)
            if (m_done[p] && (!any || m_t[p] < wt)) begin m_win = p; wt = m_t[p]; any = 1; end
          if (any && wt < m_best) m_best = wt;
          m_state = 3; m_scan = 0; m_dout = 0;
        end
        m_k++;
      end
      default: begin
        if (bus.start) begin
          m_state = 1; m_wait = int'(bus.random_delay) * DS; m_w = 0;
          m_done = '0; m_fs = '0; m_to = 1'b0; m_t = '{default: 0}; m_scan = 0; m_dout = 0;
        end else if (m_state == 3) begin
          m_dout = (m_t[m_scan / ND] / (10 ** (m_scan % ND))) % 10;
          m_scan = (m_scan + 1) % (NP * ND);
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("state", 32'(bus.state_o), 32'(m_state));
    chk("react", 32'(bus.react), 32'(m_state == 2));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("false_start", 32'(bus.false_start), 32'(m_fs));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
    chk("times0", 32'(bus.times[11:0]), 32'(to_bcd(m_t[0])));
    chk("times1", 32'(bus.times[23:12]), 32'(to_bcd(m_t[1])));
    chk("winner", 32'(bus.winner), 32'(m_win));
    chk("best_time", 32'(bus.best_time), 32'(to_bcd(m_best)));
    chk("digit_sel", 32'(bus.digit_sel), 32'(m_scan % ND));
    chk("player_sel", 32'(bus.player_sel), 32'(m_scan / ND));
    chk("digit_out", 32'(bus.digit_out), 32'(m_dout));
  endtask

  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One round: start pulse, optional foul on WAIT cycle fw, presses at REACT cycles k0/k1 (-1 = none),
  // optional reset at REACT cycle rk, then show_len cycles of idle-state noise on the buttons.
  task automatic round(input int rd, input int k0, input int k1, input int fw,
                       input logic [1:0] fmask, input int rk, input int show_len);
    bit ended;
    int ks [NP];
    ks[0] = k0; ks[1] = k1;
    bus.random_delay = 16'(rd);
    bus.user_trigger = '0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    ended = 0;
    for (int n = 0; n < 5000 && !ended; n++) begin
      logic [1:0] t;
      t = '0;
      rst = 1'b0;
      if (m_state == 1 && m_w == fw) t = fmask;
      if (m_state == 2) begin
        for (int p = 0; p < NP; p++)
          if (ks[p] >= 0 && ((m_k >= ks[p] && m_k <= ks[p] + 2) || m_k == ks[p] + 6)) t[p] = 1'b1;
        if (m_k == rk) rst = 1'b1;
      end
      bus.user_trigger = t;
      cyc();
      if (m_state == 0 || m_state == 3 || m_state == 4) ended = 1;
    end
    rst = 1'b0;
    chk("round_end", 32'(ended), 32'd1);
    repeat (show_len) begin
      bus.user_trigger = 2'($urandom);
      cyc();
    end
    bus.user_trigger = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.user_trigger = '0;
    bus.random_delay = '0;
    cyc();
    cyc();
    chk("rst_best", 32'(bus.best_time), 32'h999);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    rst = 1'b0;
    cyc();

    round(5, 41, 50, -1, 2'b00, -1, 13);
    chk("r1_t0", 32'(bus.times[11:0]), 32'h010);
    chk("r1_t1", 32'(bus.times[23:12]), 32'h012);
    chk("r1_win", 32'(bus.winner), 32'd0);
    chk("r1_best", 32'(bus.best_time), 32'h010);

    round(4, 80, 90, -1, 2'b00, -1, 3);
    chk("r2_t0", 32'(bus.times[11:0]), 32'h020);
    chk("r2_best", 32'(bus.best_time), 32'h010);

    round(5, 10, 10, 2, 2'b10, -1, 3);
    chk("foul_state", 32'(bus.state_o), 32'd4);
    chk("foul_fs", 32'(bus.false_start), 32'h2);

    round(2, -1, -1, -1, 2'b00, -1, 3);
    chk("to_flag", 32'(bus.timeout), 32'd1);
    chk("to_times", 32'(bus.times), 32'h999999);
    chk("to_best", 32'(bus.best_time), 32'h010);

    round(3, 7, 7, -1, 2'b00, -1, 4);
    chk("both_t", 32'(bus.times), 32'h001001);
    chk("both_best", 32'(bus.best_time), 32'h001);

    round(4, 20, 30, -1, 2'b00, 15, 2);
    chk("midrst_best", 32'(bus.best_time), 32'h999);

    for (int r = 0; r < 30; r++) begin
      int rd, k0, k1, fw, rk;
      rd = $urandom_range(0, 12);
      k0 = $urandom_range(0, 60);
      k1 = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 60);
      fw = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rd) : -1;
      rk = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : -1;
      round(rd, k0, k1, fw, 2'($urandom_range(1, 3)), rk, $urandom_range(1, 14));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
